bus_regfile: RTL and testbench

- Parametrised register bank for the bus-based datapath: NUM_REGS general registers of DATA_W bits.
- One register is a program counter with auto-increment.
- Adds per-register busy (scoreboard) bits so long-latency units (CORDIC, future multi-cycle ALU ops) can reserve a destination and write it back later through a valid/ready port.
- Sits between the bus multiplexer and the control FSM; replaces discrete per-register load/hold logic.

---
 rtl/bus_regfile_if.sv | 47 ++++
 rtl/bus_regfile.sv | 110 +++++++++++
 tb/tb_bus_regfile.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_regfile_if.sv
// Bus-side port bundle for bus_regfile: bus write, PC increment, two read
// ports, scoreboard reserve and the valid/ready write-back channel.
// master = datapath/control side driving requests, slave = the register file.
interface bus_regfile_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) ();

  logic                bus_wr_en;
  logic [IDX_W-1:0]    bus_wr_idx;
  logic [DATA_W-1:0]   bus_wdata;
  logic                incr_pc;
  logic [IDX_W-1:0]    rd_idx_a;
  logic [DATA_W-1:0]   rd_data_a;
  logic [IDX_W-1:0]    rd_idx_b;
  logic [DATA_W-1:0]   rd_data_b;
  logic                rd_busy_a;
  logic                rd_busy_b;
  logic                reserve_en;
  logic [IDX_W-1:0]    reserve_idx;
  logic                wb_valid;
  logic [IDX_W-1:0]    wb_idx;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_ready;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_W-1:0]   pc;
  logic                hazard;
  logic                wb_err;

  modport master (
    output bus_wr_en, bus_wr_idx, bus_wdata, incr_pc,
    output rd_idx_a, rd_idx_b, reserve_en, reserve_idx,
    output wb_valid, wb_idx, wb_data,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
    input  wb_ready, busy, pc, hazard, wb_err
  );

  modport slave (
    input  bus_wr_en, bus_wr_idx, bus_wdata, incr_pc,
    input  rd_idx_a, rd_idx_b, reserve_en, reserve_idx,
    input  wb_valid, wb_idx, wb_data,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
    output wb_ready, busy, pc, hazard, wb_err
  );

endinterface

// File: rtl/bus_regfile.sv
// Register bank with PC auto-increment and per-register busy scoreboard.
// Latency: reads combinational (no bypass); every state update and flag lands one clock later.
// Backpressure: wb_ready drops only when a same-cycle bus write targets wb_idx.
//
// Ports: clk, rst (async, active-high) plus the rf bundle (bus_regfile_if.slave):
//   bus write (bus_wr_en/idx/wdata), incr_pc, read ports A/B with busy bits,
//   reserve_en/idx, write-back wb_valid/idx/data -> wb_ready, and the
//   busy vector, pc, hazard and wb_err outputs.
module bus_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int PC_IDX   = NUM_REGS - 1,
  parameter int PC_STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  bus_regfile_if.slave  rf
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                hazard_q;
  logic                wb_err_q;

  localparam logic [IDX_W-1:0] PC_SEL = IDX_W'(PC_IDX);

  // Indices beyond NUM_REGS exist whenever NUM_REGS is not a power of two.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    int unsigned v;
    v = 32'(idx);
    return v < NUM_REGS;
  endfunction

  function automatic logic busy_at(input logic [IDX_W-1:0] idx,
                                   input logic [NUM_REGS-1:0] vec);
    return in_range(idx) ? vec[idx] : 1'b0;
  endfunction

  logic bus_in, wb_in, rsv_in;
  logic wb_ready;
  logic wb_fire;
  logic bus_ok, bus_blk;
  logic pc_touched, pc_inc, pc_blk;

  always_comb begin
    bus_in   = in_range(rf.bus_wr_idx);
    wb_in    = in_range(rf.wb_idx);
    rsv_in   = in_range(rf.reserve_idx);

    // Out-of-range write-backs are still acknowledged so the producer drains.
    wb_ready = !(rf.bus_wr_en && (rf.bus_wr_idx == rf.wb_idx));
    wb_fire  = rf.wb_valid && wb_ready && wb_in;

    // A write-back to the bus target is always stalled by wb_ready, so it can
    // never release the register in the same cycle: a busy target blocks.
    bus_blk  = rf.bus_wr_en && bus_in &&  busy_at(rf.bus_wr_idx, busy_q);
    bus_ok   = rf.bus_wr_en && bus_in && !busy_at(rf.bus_wr_idx, busy_q);

    // Any bus/write-back aimed at the PC overrides incr_pc, even a blocked
    // bus write (which raises hazard on its own).
    pc_touched = (rf.bus_wr_en && (rf.bus_wr_idx == PC_SEL)) ||
                 (wb_fire && (rf.wb_idx == PC_SEL));
    pc_inc     = rf.incr_pc && !pc_touched && !busy_q[PC_IDX];
    pc_blk     = rf.incr_pc && !pc_touched &&  busy_q[PC_IDX];
  end

  // Reserve is applied after write-back clear so a fresh reservation wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_fire)
      busy_nxt[rf.wb_idx] = 1'b0;
    if (rf.reserve_en && rsv_in)
      busy_nxt[rf.reserve_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy_q   <= '0;
      hazard_q <= 1'b0;
      wb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus_ok && (rf.bus_wr_idx == IDX_W'(i)))
          regs[i] <= rf.bus_wdata;
        else if (wb_fire && (rf.wb_idx == IDX_W'(i)))
          regs[i] <= rf.wb_data;
        else if (pc_inc && (i == PC_IDX))
          regs[i] <= regs[i] + DATA_W'(PC_STEP);
      end
      busy_q   <= busy_nxt;
      hazard_q <= bus_blk || pc_blk;
      wb_err_q <= wb_fire && !busy_q[rf.wb_idx];
    end
  end

  assign rf.rd_data_a = in_range(rf.rd_idx_a) ? regs[rf.rd_idx_a] : '0;
  assign rf.rd_data_b = in_range(rf.rd_idx_b) ? regs[rf.rd_idx_b] : '0;
  assign rf.rd_busy_a = busy_at(rf.rd_idx_a, busy_q);
  assign rf.rd_busy_b = busy_at(rf.rd_idx_b, busy_q);
  assign rf.wb_ready  = wb_ready;
  assign rf.busy      = busy_q;
  assign rf.pc        = regs[PC_IDX];
  assign rf.hazard    = hazard_q;
  assign rf.wb_err    = wb_err_q;

endmodule

// File: tb/tb_bus_regfile.sv
// Directed bench for bus_regfile: a default 32x32 instance and a 12x16
// instance (out-of-range indices, 16-bit PC wrap), sharing clk and rst.
module tb_bus_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_regfile_if #(.DATA_W(32), .NUM_REGS(32)) ifa ();
  bus_regfile_if #(.DATA_W(16), .NUM_REGS(12)) ifb ();

  bus_regfile #(.DATA_W(32), .NUM_REGS(32)) dut_a (.clk(clk), .rst(rst), .rf(ifa));
  bus_regfile #(.DATA_W(16), .NUM_REGS(12)) dut_b (.clk(clk), .rst(rst), .rf(ifb));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.bus_wr_en = 1'b0; ifa.incr_pc = 1'b0;
    ifa.reserve_en = 1'b0; ifa.wb_valid = 1'b0;
  endtask

  task automatic idle_b();
    ifb.bus_wr_en = 1'b0; ifb.incr_pc = 1'b0;
    ifb.reserve_en = 1'b0; ifb.wb_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input int idx, input logic [63:0] exp);
    ifa.rd_idx_a = 5'(idx);
    #1;
    check(tag, ifa.rd_data_a, exp);
  endtask

  task automatic bus_a(input int idx, input logic [31:0] d);
    ifa.bus_wr_en = 1'b1; ifa.bus_wr_idx = 5'(idx); ifa.bus_wdata = d;
  endtask

  task automatic wb_a(input int idx, input logic [31:0] d);
    ifa.wb_valid = 1'b1; ifa.wb_idx = 5'(idx); ifa.wb_data = d;
  endtask

  task automatic rsv_a(input int idx);
    ifa.reserve_en = 1'b1; ifa.reserve_idx = 5'(idx);
  endtask

  initial begin
    idle_a(); idle_b();
    ifa.bus_wr_idx = '0; ifa.bus_wdata = '0; ifa.rd_idx_a = '0; ifa.rd_idx_b = '0;
    ifa.reserve_idx = '0; ifa.wb_idx = '0; ifa.wb_data = '0;
    ifb.bus_wr_idx = '0; ifb.bus_wdata = '0; ifb.rd_idx_a = '0; ifb.rd_idx_b = '0;
    ifb.reserve_idx = '0; ifb.wb_idx = '0; ifb.wb_data = '0;

    step(); step();
    rst = 1'b0;
    step();
    check("rst_pc", ifa.pc, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_hazard", ifa.hazard, 0);
    check("rst_wb_err", ifa.wb_err, 0);

    // PC=5 and R7 reserved, then an asynchronous mid-cycle reset.
    bus_a(31, 32'd5); rsv_a(7);
    step(); idle_a();
    check("pre_rst_pc", ifa.pc, 5);
    check("pre_rst_busy", ifa.busy, 32'h80);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", ifa.pc, 0);
    check("async_rst_busy", ifa.busy, 0);
    #1 rst = 1'b0;

    ifa.incr_pc = 1'b1;
    step(); step(); step();
    check("incr3_pc", ifa.pc, 3);
    idle_a(); bus_a(31, 32'hFFFF_FFFF);
    step(); idle_a();
    check("pc_max", ifa.pc, 32'hFFFF_FFFF);
    ifa.incr_pc = 1'b1;
    step(); idle_a();
    check("pc_wrap", ifa.pc, 0);

    // Bus write elsewhere coexists with incr_pc; bus write to PC overrides it.
    bus_a(4, 32'hA5); ifa.incr_pc = 1'b1;
    step(); idle_a();
    rd_a("r4_bus", 4, 32'hA5);
    check("pc_incr_with_bus", ifa.pc, 1);
    bus_a(31, 32'h100); ifa.incr_pc = 1'b1;
    step(); idle_a();
    check("pc_bus_over_incr", ifa.pc, 32'h100);

    // Scoreboard: blocked bus write, then write-back releases R7.
    rsv_a(7);
    step(); idle_a();
    check("rsv7_busy", ifa.busy, 32'h80);
    bus_a(7, 32'h11);
    step(); idle_a();
    check("hazard_pulse", ifa.hazard, 1);
    rd_a("r7_blocked", 7, 0);
    step();
    check("hazard_one_cycle", ifa.hazard, 0);
    wb_a(7, 32'h3FFF);
    #1;
    check("wb7_ready", ifa.wb_ready, 1);
    step(); idle_a();
    rd_a("r7_wb", 7, 32'h3FFF);
    check("wb7_busy_clr", ifa.busy, 0);
    check("wb7_rd_busy_a", ifa.rd_busy_a, 0);
    check("wb7_no_err", ifa.wb_err, 0);

    // Write-back stalled by a same-index bus write.
    wb_a(3, 32'h22); bus_a(3, 32'h99);
    #1;
    check("wb3_stall_ready", ifa.wb_ready, 0);
    step();
    ifa.bus_wr_en = 1'b0;
    rd_a("r3_bus", 3, 32'h99);
    check("wb3_stall_no_err", ifa.wb_err, 0);
    check("wb3_retry_ready", ifa.wb_ready, 1);
    step(); idle_a();
    rd_a("r3_wb", 3, 32'h22);
    check("wb3_err", ifa.wb_err, 1);
    step();
    check("wb_err_one_cycle", ifa.wb_err, 0);

    // Reserve and write-back to R9 in the same cycle: reservation survives.
    rsv_a(9);
    step(); idle_a();
    rsv_a(9); wb_a(9, 32'h55);
    step(); idle_a();
    rd_a("r9_wb", 9, 32'h55);
    check("r9_busy_kept", ifa.busy, 32'h200);
    check("r9_no_err", ifa.wb_err, 0);
    ifa.rd_idx_b = 5'd9;
    #1;
    check("r9_rd_busy_b", ifa.rd_busy_b, 1);
    wb_a(2, 32'h77);
    step(); idle_a();
    check("stray_wb_err", ifa.wb_err, 1);
    rd_a("r2_stray", 2, 32'h77);

    // Busy PC: incr_pc blocked with hazard; write-back to PC beats incr_pc.
    rsv_a(31);
    step(); idle_a();
    ifa.incr_pc = 1'b1;
    step(); idle_a();
    check("pc_busy_hold", ifa.pc, 32'h100);
    check("pc_busy_hazard", ifa.hazard, 1);
    ifa.incr_pc = 1'b1; wb_a(31, 32'h200);
    step(); idle_a();
    check("pc_wb", ifa.pc, 32'h200);
    check("pc_wb_no_hazard", ifa.hazard, 0);
    check("pc_wb_busy", ifa.busy, 32'h200);

    // 12 x 16 instance: out-of-range index 13, PC at 11 wraps 0xFFFF -> 0.
    ifb.bus_wr_en = 1'b1; ifb.bus_wr_idx = 4'd13; ifb.bus_wdata = 16'h1234;
    step(); idle_b();
    check("b_oor_busy", ifb.busy, 0);
    check("b_oor_hazard", ifb.hazard, 0);
    check("b_oor_pc", ifb.pc, 0);
    ifb.rd_idx_a = 4'd13;
    #1;
    check("b_oor_rd", ifb.rd_data_a, 0);
    check("b_oor_rd_busy", ifb.rd_busy_a, 0);
    ifb.reserve_en = 1'b1; ifb.reserve_idx = 4'd13;
    ifb.wb_valid = 1'b1; ifb.wb_idx = 4'd13; ifb.wb_data = 16'hBEEF;
    #1;
    check("b_oor_wb_ready", ifb.wb_ready, 1);
    step(); idle_b();
    check("b_oor_rsv_busy", ifb.busy, 0);
    check("b_oor_wb_err", ifb.wb_err, 0);
    ifb.bus_wr_en = 1'b1; ifb.bus_wr_idx = 4'd11; ifb.bus_wdata = 16'hFFFF;
    step(); idle_b();
    check("b_pc_max", ifb.pc, 16'hFFFF);
    ifb.incr_pc = 1'b1;
    step(); idle_b();
    check("b_pc_wrap", ifb.pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
